// File: rtl/stage2.sv
// stage2: SDF FFT twiddle stage, upper branch delayed, lower branch x W_N^k.
// Define STAGE2_SAT_EN to clamp dout2 and report ovf; otherwise results wrap.
module stage2 #(
  parameter int SIGN_BIT = 1,
  parameter int INT_BIT  = 3,
  parameter int FR_BIT   = 6,
  parameter int N        = 16,
  parameter int TW_FR    = 7,
  localparam int DW      = SIGN_BIT + INT_BIT + FR_BIT
) (
  input  logic                 clk,
  input  logic                 rstn,
  input  logic                 start,
  input  logic                 din_vld,
  input  logic signed [DW-1:0] din1_re,
  input  logic signed [DW-1:0] din1_im,
  input  logic signed [DW-1:0] din2_re,
  input  logic signed [DW-1:0] din2_im,
  output logic signed [DW-1:0] dout1_re,
  output logic signed [DW-1:0] dout1_im,
  output logic signed [DW-1:0] dout2_re,
  output logic signed [DW-1:0] dout2_im,
  output logic                 dout_vld,
  output logic                 stop,
  output logic                 ovf
);

  localparam int TW_W = TW_FR + 2;
  localparam int P    = N / 2;
  localparam int KW   = $clog2(P);
  localparam int PW   = DW + TW_W;
  localparam int SW   = PW + 1;

  localparam logic signed [SW-1:0] RND =
    SW'(2 ** (TW_FR - 1));
  localparam logic signed [SW-1:0] MAXV =
    SW'(2 ** (DW - 1) - 1);
  localparam logic signed [SW-1:0] MINV =
    SW'(-(2 ** (DW - 1)));

  function automatic logic signed [TW_W-1:0] tw(
    input int kk,
    input bit sn
  );
    real ang;
    real v;
    ang = 6.283185307179586 * real'(kk) / real'(N);
    v   = sn ? $sin(ang) : $cos(ang);
    v   = v * real'(2 ** TW_FR);
    return TW_W'($rtoi($floor(v + 0.5)));
  endfunction

  logic signed [TW_W-1:0] w_rom_c [P];
  logic signed [TW_W-1:0] w_rom_s [P];

  for (genvar g = 0; g < P; g++) begin : g_rom
    assign w_rom_c[g] = tw(g, 1'b0);
    assign w_rom_s[g] = tw(g, 1'b1);
  end

  logic [KW-1:0] r_k;
  logic [KW-1:0] w_k;
  logic          w_last;

  assign w_k    = start ? '0 : r_k;
  assign w_last = (w_k == KW'(P - 1));

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_k <= '0;
    end else if (din_vld) begin
      r_k <= w_k + KW'(1);
    end else if (start) begin
      r_k <= '0;
    end
  end

  logic                   r1_vld;
  logic                   r1_last;
  logic signed [DW-1:0]   r1_d1re;
  logic signed [DW-1:0]   r1_d1im;
  logic signed [DW-1:0]   r1_a;
  logic signed [DW-1:0]   r1_b;
  logic signed [TW_W-1:0] r1_c;
  logic signed [TW_W-1:0] r1_s;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r1_vld  <= 1'b0;
      r1_last <= 1'b0;
      r1_d1re <= '0;
      r1_d1im <= '0;
      r1_a    <= '0;
      r1_b    <= '0;
      r1_c    <= '0;
      r1_s    <= '0;
    end else begin
      r1_vld <= din_vld;
      if (din_vld) begin
        r1_last <= w_last;
        r1_d1re <= din1_re;
        r1_d1im <= din1_im;
        r1_a    <= din2_re;
        r1_b    <= din2_im;
        r1_c    <= w_rom_c[w_k];
        r1_s    <= w_rom_s[w_k];
      end
    end
  end

  logic                 r2_vld;
  logic                 r2_last;
  logic signed [DW-1:0] r2_d1re;
  logic signed [DW-1:0] r2_d1im;
  logic signed [PW-1:0] r2_ac;
  logic signed [PW-1:0] r2_bs;
  logic signed [PW-1:0] r2_bc;
  logic signed [PW-1:0] r2_as;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r2_vld  <= 1'b0;
      r2_last <= 1'b0;
      r2_d1re <= '0;
      r2_d1im <= '0;
      r2_ac   <= '0;
      r2_bs   <= '0;
      r2_bc   <= '0;
      r2_as   <= '0;
    end else begin
      r2_vld <= r1_vld;
      if (r1_vld) begin
        r2_last <= r1_last;
        r2_d1re <= r1_d1re;
        r2_d1im <= r1_d1im;
        r2_ac   <= PW'(r1_a) * PW'(r1_c);
        r2_bs   <= PW'(r1_b) * PW'(r1_s);
        r2_bc   <= PW'(r1_b) * PW'(r1_c);
        r2_as   <= PW'(r1_a) * PW'(r1_s);
      end
    end
  end

  logic signed [SW-1:0] w_re;
  logic signed [SW-1:0] w_im;
  logic signed [SW-1:0] w_re_sh;
  logic signed [SW-1:0] w_im_sh;
  logic signed [DW-1:0] w_re_o;
  logic signed [DW-1:0] w_im_o;
  logic                 w_ovf;

  assign w_re    = SW'(r2_ac) + SW'(r2_bs);
  assign w_im    = SW'(r2_bc) - SW'(r2_as);
  assign w_re_sh = (w_re + RND) >>> TW_FR;
  assign w_im_sh = (w_im + RND) >>> TW_FR;

  always_comb begin
    w_re_o = DW'(w_re_sh);
    w_im_o = DW'(w_im_sh);
    w_ovf  = 1'b0;
`ifdef STAGE2_SAT_EN
    if (w_re_sh > MAXV) begin
      w_re_o = DW'(MAXV);
      w_ovf  = 1'b1;
    end else if (w_re_sh < MINV) begin
      w_re_o = DW'(MINV);
      w_ovf  = 1'b1;
    end
    if (w_im_sh > MAXV) begin
      w_im_o = DW'(MAXV);
      w_ovf  = 1'b1;
    end else if (w_im_sh < MINV) begin
      w_im_o = DW'(MINV);
      w_ovf  = 1'b1;
    end
`else
    w_ovf = 1'b0;
`endif
  end

  logic                 r_vld;
  logic                 r_stop;
  logic                 r_ovf;
  logic signed [DW-1:0] r_d1re;
  logic signed [DW-1:0] r_d1im;
  logic signed [DW-1:0] r_d2re;
  logic signed [DW-1:0] r_d2im;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_vld  <= 1'b0;
      r_stop <= 1'b0;
      r_ovf  <= 1'b0;
      r_d1re <= '0;
      r_d1im <= '0;
      r_d2re <= '0;
      r_d2im <= '0;
    end else begin
      r_vld  <= r2_vld;
      r_stop <= r2_vld & r2_last;
      r_ovf  <= r2_vld & w_ovf;
      if (r2_vld) begin
        r_d1re <= r2_d1re;
        r_d1im <= r2_d1im;
        r_d2re <= w_re_o;
        r_d2im <= w_im_o;
      end
    end
  end

  assign dout1_re = r_d1re;
  assign dout1_im = r_d1im;
  assign dout2_re = r_d2re;
  assign dout2_im = r_d2im;
  assign dout_vld = r_vld;
  assign stop     = r_stop;
  assign ovf      = r_ovf;

endmodule

// File: tb/tb_stage2.sv
// tb_stage2: randomized and directed bench for stage2 against a
// cycle-indexed expectation table built from the twiddle-multiply rules.
module tb_stage2;

  localparam int DW    = 10;
  localparam int N     = 16;
  localparam int P     = N / 2;
  localparam int TW_FR = 7;
  localparam int DEPTH = 2048;

  logic                 clk = 1'b0;
  logic                 rstn;
  logic                 start;
  logic                 din_vld;
  logic signed [DW-1:0] din1_re;
  logic signed [DW-1:0] din1_im;
  logic signed [DW-1:0] din2_re;
  logic signed [DW-1:0] din2_im;
  logic signed [DW-1:0] dout1_re;
  logic signed [DW-1:0] dout1_im;
  logic signed [DW-1:0] dout2_re;
  logic signed [DW-1:0] dout2_im;
  logic                 dout_vld;
  logic                 stop;
  logic                 ovf;

  always #5 clk = ~clk;

  stage2 dut (
    .clk     (clk),
    .rstn    (rstn),
    .start   (start),
    .din_vld (din_vld),
    .din1_re (din1_re),
    .din1_im (din1_im),
    .din2_re (din2_re),
    .din2_im (din2_im),
    .dout1_re(dout1_re),
    .dout1_im(dout1_im),
    .dout2_re(dout2_re),
    .dout2_im(dout2_im),
    .dout_vld(dout_vld),
    .stop    (stop),
    .ovf     (ovf)
  );

  int n_chk  = 0;
  int n_pass = 0;
  int cyc    = 0;
  int mk     = 0;

  bit ev [DEPTH];
  bit es [DEPTH];
  bit eo [DEPTH];
  int e1r [DEPTH];
  int e1i [DEPTH];
  int e2r [DEPTH];
  int e2i [DEPTH];

  int h1r = 0, h1i = 0, h2r = 0, h2i = 0;

  int q1r [$];
  int q1i [$];
  int q2r [$];
  int q2i [$];
  bit qs  [$];
  bit qo  [$];

  task automatic chk(string tag, longint got, longint exp);
    n_chk++;
    if (got == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
  endtask

  function automatic longint twf(int k, bit sn);
    real a;
    real v;
    a = 2.0 * 3.141592653589793 * real'(k) / real'(N);
    v = (sn ? $sin(a) : $cos(a)) * real'(2 ** TW_FR);
    return longint'($rtoi($floor(v + 0.5)));
  endfunction

  function automatic longint fit(longint v, output bit o);
    longint m;
    o = 1'b0;
`ifdef STAGE2_SAT_EN
    if (v > 511) begin
      o = 1'b1;
      return 511;
    end
    if (v < -512) begin
      o = 1'b1;
      return -512;
    end
    return v;
`else
    m = v % 1024;
    if (m < 0) m += 1024;
    if (m >= 512) m -= 1024;
    return m;
`endif
  endfunction

  task automatic observe();
    int c;
    c = cyc;
    if (ev[c]) begin
      h1r = e1r[c];
      h1i = e1i[c];
      h2r = e2r[c];
      h2i = e2i[c];
    end
    chk("dout_vld", dout_vld, ev[c]);
    chk("stop", stop, es[c]);
    chk("ovf", ovf, eo[c]);
    chk("dout1_re", dout1_re, h1r);
    chk("dout1_im", dout1_im, h1i);
    chk("dout2_re", dout2_re, h2r);
    chk("dout2_im", dout2_im, h2i);
    if (dout_vld) begin
      q1r.push_back(int'(dout1_re));
      q1i.push_back(int'(dout1_im));
      q2r.push_back(int'(dout2_re));
      q2i.push_back(int'(dout2_im));
      qs.push_back(stop);
      qo.push_back(ovf);
    end
  endtask

  task automatic drive(bit st, bit vld,
                       int a1r, int a1i, int a2r, int a2i);
    int kk;
    int ix;
    longint c, s, re, im;
    bit o1, o2;
    start   = st;
    din_vld = vld;
    din1_re = DW'(a1r);
    din1_im = DW'(a1i);
    din2_re = DW'(a2r);
    din2_im = DW'(a2i);
    if (rstn) begin
      kk = st ? 0 : mk;
      if (vld) begin
        c  = twf(kk, 1'b0);
        s  = twf(kk, 1'b1);
        re = longint'(a2r) * c + longint'(a2i) * s;
        im = longint'(a2i) * c - longint'(a2r) * s;
        re = (re + 64) >>> TW_FR;
        im = (im + 64) >>> TW_FR;
        ix = cyc + 3;
        ev[ix]  = 1'b1;
        es[ix]  = (kk == P - 1);
        e1r[ix] = a1r;
        e1i[ix] = a1i;
        e2r[ix] = int'(fit(re, o1));
        e2i[ix] = int'(fit(im, o2));
        eo[ix]  = o1 | o2;
        mk = (kk + 1) % P;
      end else if (st) begin
        mk = 0;
      end
    end
    @(posedge clk);
    #1;
    cyc++;
    observe();
  endtask

  task automatic idle(int n);
    for (int i = 0; i < n; i++) drive(1'b0, 1'b0, 0, 0, 0, 0);
  endtask

  function automatic int rnd();
    return int'($urandom_range(0, 1023)) - 512;
  endfunction

  task automatic qclear();
    q1r.delete();
    q1i.delete();
    q2r.delete();
    q2i.delete();
    qs.delete();
    qo.delete();
  endtask

  initial begin
    rstn    = 1'b0;
    start   = 1'b1;
    din_vld = 1'b1;
    din1_re = '1;
    din1_im = 10'sd77;
    din2_re = -10'sd3;
    din2_im = 10'sd200;
    for (int i = 0; i < 4; i++)
      drive(1'($urandom), 1'b1, rnd(), rnd(), rnd(), rnd());
    rstn = 1'b1;
    idle(3);
    qclear();

    drive(1'b1, 1'b1, 10, -5, 64, 0);
    drive(1'b0, 1'b1, 1, 2, 0, 0);
    drive(1'b0, 1'b1, 3, 4, 64, 0);
    drive(1'b0, 1'b1, 5, 6, 0, 0);
    drive(1'b0, 1'b1, 7, 8, 64, 32);
    drive(1'b1, 1'b1, 0, 0, 0, 0);
    drive(1'b0, 1'b1, 0, 0, 0, 0);
    drive(1'b0, 1'b1, 0, 0, 511, 511);
    idle(4);
    chk("dir_count", q2r.size(), 8);
    if (q2r.size() == 8) begin
      chk("k0_d1re", q1r[0], 10);
      chk("k0_d1im", q1i[0], -5);
      chk("k0_d2re", q2r[0], 64);
      chk("k0_d2im", q2i[0], 0);
      chk("k0_stop", qs[0], 0);
      chk("k2_re", q2r[2], 46);
      chk("k2_im", q2i[2], -45);
      chk("k4_re", q2r[4], 32);
      chk("k4_im", q2i[4], -64);
`ifdef STAGE2_SAT_EN
      chk("k2max_re", q2r[7], 511);
      chk("k2max_ovf", qo[7], 1);
`else
      chk("k2max_re", q2r[7], -297);
      chk("k2max_ovf", qo[7], 0);
`endif
      chk("k2max_im", q2i[7], 0);
    end

    qclear();
    drive(1'b1, 1'b1, 100, 0, 0, 0);
    for (int i = 1; i < 8; i++)
      drive(1'b0, 1'b1, 100 + i, 0, 0, 0);
    drive(1'b0, 1'b1, 108, 0, 64, 32);
    drive(1'b0, 1'b0, 0, 0, 0, 0);
    drive(1'b0, 1'b1, 109, 0, rnd(), rnd());
    idle(4);
    chk("burst_count", q2r.size(), 10);
    if (q2r.size() == 10) begin
      for (int i = 0; i < 10; i++)
        chk($sformatf("burst_stop%0d", i), qs[i], i == 7);
      chk("wrap_k0_re", q2r[8], 64);
      chk("wrap_k0_im", q2i[8], 32);
      chk("burst_last_d1", q1r[9], 109);
    end

    for (int i = 0; i < 300; i++)
      drive($urandom_range(0, 19) == 0,
            $urandom_range(0, 3) != 0,
            rnd(), rnd(), rnd(), rnd());
    idle(4);

    drive(1'b1, 1'b1, rnd(), rnd(), rnd(), rnd());
    for (int i = 0; i < 4; i++)
      drive(1'b0, 1'b1, rnd(), rnd(), rnd(), rnd());
    chk("pre_rst_vld", dout_vld, 1);
    #2;
    rstn = 1'b0;
    #1;
    chk("rst_vld", dout_vld, 0);
    chk("rst_stop", stop, 0);
    chk("rst_ovf", ovf, 0);
    chk("rst_d2re", dout2_re, 0);
    chk("rst_d1re", dout1_re, 0);
    for (int i = 0; i < 4; i++) ev[cyc + i] = 1'b0;
    h1r = 0;
    h1i = 0;
    h2r = 0;
    h2i = 0;
    mk  = 0;
    drive(1'b0, 1'b1, rnd(), rnd(), rnd(), rnd());
    rstn = 1'b1;
    idle(4);
    for (int i = 0; i < 40; i++)
      drive(1'b0, $urandom_range(0, 1) == 1,
            rnd(), rnd(), rnd(), rnd());
    idle(4);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
